// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//
// Parametrised single-clock FIFO with registered read data, occupancy count,
// programmable almost-full / almost-empty thresholds and optional sticky
// overflow / underflow debug flags.
//
// Configuration macro:
//   SYNC_FIFO_ERR_EN  - when defined, overflow/underflow sticky flags and the
//                       err_clr input are live; otherwise the flags are tied
//                       to 0 and err_clr is ignored. Port list is identical.
//
// Parameters:
//   DATA_WIDTH  word width (>= 1)
//   DEPTH       number of entries (power of 2, >= 2)
//   AF_LEVEL    almost_full  when fifo_cnt >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL    almost_empty when fifo_cnt <= AE_LEVEL (0..DEPTH-1)
//   CW          count width, $clog2(DEPTH)+1 (derived)
//
// Ports:
//   clk           clock, all state updates on rising edge
//   rst           asynchronous active-low reset
//   writeEnable   write request
//   readEnable    read request
//   data_in       write data
//   err_clr       synchronous clear of sticky error flags
//   data_out      registered read data (valid the cycle after an accepted read)
//   full          fifo_cnt == DEPTH
//   empty         fifo_cnt == 0
//   almost_full   fifo_cnt >= AF_LEVEL
//   almost_empty  fifo_cnt <= AE_LEVEL
//   fifo_cnt      current occupancy, 0..DEPTH
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
// -----------------------------------------------------------------------------
module sync_fifo_param #(
   parameter int  DATA_WIDTH = 8,
   parameter int  DEPTH      = 16,
   parameter int  AF_LEVEL   = 14,
   parameter int  AE_LEVEL   = 2,
   localparam int CW         = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  writeEnable,
   input  logic                  readEnable,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  err_clr,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CW-1:0]         fifo_cnt,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

   logic wr_acc;
   logic rd_acc;

   // Status flags decode straight from the registered count, so they only
   // move on a clock edge or reset.
   assign full         = (cnt_q == CW'(DEPTH));
   assign empty        = (cnt_q == '0);
   assign almost_full  = (cnt_q >= CW'(AF_LEVEL));
   assign almost_empty = (cnt_q <= CW'(AE_LEVEL));
   assign fifo_cnt     = cnt_q;
   assign data_out     = data_out_q;

   // A write is allowed at full only when a read frees a slot on the same
   // edge. Reads are never accepted at empty, so there is no fall-through.
   assign wr_acc = writeEnable && (!full || readEnable);
   assign rd_acc = readEnable && !empty;

   // NOTE: every signal driven in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      data_out_d = data_out_q;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
         rd_ptr_d   = rd_ptr_q + AW'(1);
         data_out_d = mem[rd_ptr_q];
      end

      if (wr_acc && !rd_acc) begin
         cnt_d = cnt_q + CW'(1);
      end else if (rd_acc && !wr_acc) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // sample the pre-edge values; this is also what lets a read and a write to
   // the same slot at full return the old word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         data_out_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         data_out_q <= data_out_d;
      end
   end

   // NOTE: the storage array has no reset; contents are meaningless until
   // written, and leaving it out lets it map onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr_q] <= data_in;
      end
   end

`ifdef SYNC_FIFO_ERR_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   // Set has priority over clear on the same edge.
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (writeEnable && full && !readEnable) begin
         overflow_d = 1'b1;
      end
      if (readEnable && empty) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign overflow       = 1'b0;
   assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
//
// Self-checking bench for sync_fifo_param at default parameters (8 x 16,
// AF 14, AE 2). A table of {inputs, expected outputs} records drives the
// fill / overflow / drain / underflow / clear sequence; hand-written
// sequences cover wrap-around, simultaneous access at full and at empty,
// set-vs-clear priority and asynchronous mid-stream reset.
// Error-flag expectations follow SYNC_FIFO_ERR_EN.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

   localparam int DW = 8;
   localparam int CW = 5;

`ifdef SYNC_FIFO_ERR_EN
   localparam logic E = 1'b1;
`else
   localparam logic E = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          writeEnable;
   logic          readEnable;
   logic [DW-1:0] data_in;
   logic          err_clr;
   logic [DW-1:0] data_out;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [CW-1:0] fifo_cnt;
   logic          overflow;
   logic          underflow;

   int checks   = 0;
   int failures = 0;

   sync_fifo_param #(
      .DATA_WIDTH(8),
      .DEPTH     (16),
      .AF_LEVEL  (14),
      .AE_LEVEL  (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .writeEnable (writeEnable),
      .readEnable  (readEnable),
      .data_in     (data_in),
      .err_clr     (err_clr),
      .data_out    (data_out),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .almost_empty(almost_empty),
      .fifo_cnt    (fifo_cnt),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          wr;
      logic          rd;
      logic          clr;
      logic [DW-1:0] din;
      int            cnt;
      logic [DW-1:0] dout;
      logic          ovf;
      logic          unf;
   } vec_t;

   localparam int NV = 35;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Compare every output against an expected count, read data and error flags.
   // Flag expectations use the documented thresholds: full 16, AF 14, AE 2.
   task automatic check_state(input string tag, input int cnt, input logic [DW-1:0] dout,
                              input logic ovf, input logic unf);
      check({tag, "_cnt"},   32'(fifo_cnt),     32'(cnt));
      check({tag, "_full"},  32'(full),         32'(cnt == 16));
      check({tag, "_empty"}, 32'(empty),        32'(cnt == 0));
      check({tag, "_af"},    32'(almost_full),  32'(cnt >= 14));
      check({tag, "_ae"},    32'(almost_empty), 32'(cnt <= 2));
      check({tag, "_dout"},  32'(data_out),     32'(dout));
      check({tag, "_ovf"},   32'(overflow),     32'(ovf));
      check({tag, "_unf"},   32'(underflow),    32'(unf));
   endtask

   // Drive one cycle of requests at the falling edge, sample 1 time unit after
   // the rising edge, then return the inputs to idle.
   task automatic cycle(input logic wr, input logic rd, input logic [DW-1:0] din, input logic clr);
      @(negedge clk);
      writeEnable = wr;
      readEnable  = rd;
      data_in     = din;
      err_clr     = clr;
      @(posedge clk);
      #1;
      writeEnable = 1'b0;
      readEnable  = 1'b0;
      err_clr     = 1'b0;
   endtask

   initial begin
      // ---------------- vector table ----------------
      // 0..15: fill with 0x00..0x0F
      for (int i = 0; i < 16; i++)
         vecs[i] = '{wr:1, rd:0, clr:0, din:DW'(i), cnt:i+1, dout:8'h00, ovf:0, unf:0};
      // 16: write while full is rejected
      vecs[16] = '{wr:1, rd:0, clr:0, din:8'h77, cnt:16, dout:8'h00, ovf:E, unf:0};
      // 17..32: drain, data appears in order one cycle after each read
      for (int k = 0; k < 16; k++)
         vecs[17+k] = '{wr:0, rd:1, clr:0, din:8'h00, cnt:15-k, dout:DW'(k), ovf:E, unf:0};
      // 33: read while empty is rejected, data_out holds
      vecs[33] = '{wr:0, rd:1, clr:0, din:8'h00, cnt:0, dout:8'h0F, ovf:E, unf:E};
      // 34: clear sticky flags
      vecs[34] = '{wr:0, rd:0, clr:1, din:8'h00, cnt:0, dout:8'h0F, ovf:0, unf:0};

      // ---------------- reset ----------------
      rst         = 1'b0;
      writeEnable = 1'b0;
      readEnable  = 1'b0;
      data_in     = '0;
      err_clr     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_state("reset", 0, 8'h00, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_state("idle", 0, 8'h00, 0, 0);

      // ---------------- table-driven ----------------
      for (int i = 0; i < NV; i++) begin
         cycle(vecs[i].wr, vecs[i].rd, vecs[i].din, vecs[i].clr);
         check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dout, vecs[i].ovf, vecs[i].unf);
      end

      // ---------------- wrap-around ----------------
      // Pointers start at 0; the second pass crosses 15 -> 0.
      for (int i = 0; i < 10; i++) cycle(1, 0, 8'h20 + DW'(i), 0);
      check_state("wrap_w10", 10, 8'h0F, 0, 0);
      for (int i = 0; i < 10; i++) begin
         cycle(0, 1, 8'h00, 0);
         check($sformatf("wrap_r10_%0d", i), 32'(data_out), 32'(8'h20 + DW'(i)));
      end
      check_state("wrap_r10_end", 0, 8'h29, 0, 0);
      for (int i = 0; i < 12; i++) cycle(1, 0, 8'h40 + DW'(i), 0);
      check_state("wrap_w12", 12, 8'h29, 0, 0);
      for (int i = 0; i < 12; i++) begin
         cycle(0, 1, 8'h00, 0);
         check($sformatf("wrap_r12_%0d", i), 32'(data_out), 32'(8'h40 + DW'(i)));
      end
      check_state("wrap_r12_end", 0, 8'h4B, 0, 0);

      // ---------------- simultaneous at full ----------------
      for (int i = 0; i < 16; i++) cycle(1, 0, 8'h60 + DW'(i), 0);
      check_state("sf_fill", 16, 8'h4B, 0, 0);
      cycle(1, 1, 8'hAA, 0);
      check_state("sf_both", 16, 8'h60, 0, 0);
      for (int i = 1; i < 16; i++) begin
         cycle(0, 1, 8'h00, 0);
         check($sformatf("sf_r%0d", i), 32'(data_out), 32'(8'h60 + DW'(i)));
      end
      cycle(0, 1, 8'h00, 0);
      check_state("sf_last_aa", 0, 8'hAA, 0, 0);

      // ---------------- simultaneous at empty ----------------
      cycle(1, 1, 8'h55, 0);
      check_state("se_both", 1, 8'hAA, 0, E);
      cycle(0, 1, 8'h00, 0);
      check_state("se_read", 0, 8'h55, 0, E);
      cycle(0, 0, 8'h00, 1);
      check_state("se_clr", 0, 8'h55, 0, 0);
      // Set and clear on the same edge: set wins.
      cycle(0, 1, 8'h00, 1);
      check_state("se_set_vs_clr", 0, 8'h55, 0, E);
      cycle(0, 0, 8'h00, 1);
      check_state("se_clr2", 0, 8'h55, 0, 0);

      // ---------------- asynchronous reset mid-stream ----------------
      for (int i = 0; i < 6; i++) cycle(1, 0, 8'h11 + DW'(i), 0);
      cycle(0, 1, 8'h00, 0);
      check_state("ar_pre", 5, 8'h11, 0, 0);
      #2;
      rst = 1'b0;
      #1;
      check_state("ar_async", 0, 8'h00, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      cycle(1, 0, 8'h99, 0);
      cycle(0, 1, 8'h00, 0);
      check_state("ar_after", 0, 8'h99, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: the next-generation storage buffer for 8-bit-style datapaths, generalised in data width and depth. Adds programmable almost-full/almost-empty thresholds, an occupancy count output, and correct simultaneous read/write handling at both boundaries. Sits between a producer and a consumer in the same clock domain. Compile-time sticky overflow/underflow error flags support debug.

## Interface
- `DATA_WIDTH`, default 8: width of each stored word; must be ≥ 1.
- `DEPTH`, default 16: number of entries; must be a power of 2 and ≥ 2.
- `AF_LEVEL`, default 14: `almost_full` asserts when count ≥ `AF_LEVEL`; range 1..DEPTH.
- `AE_LEVEL`, default 2: `almost_empty` asserts when count ≤ `AE_LEVEL`; range 0..DEPTH-1.
- `CW` = $clog2(DEPTH)+1: derived, not overridable.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `writeEnable`, in, 1: write request.
- `readEnable`, in, 1: read request.
- `data_in`, in, DATA_WIDTH: write data.
- `err_clr`, in, 1: synchronous clear of the sticky error flags.
- `data_out`, out, DATA_WIDTH: registered read data.
- `full`, out, 1: count == DEPTH.
- `empty`, out, 1: count == 0.
- `almost_full`, out, 1: count ≥ AF_LEVEL.
- `almost_empty`, out, 1: count ≤ AE_LEVEL.
- `fifo_cnt`, out, CW: current occupancy, 0..DEPTH.
- `overflow`, out, 1: sticky; a write was rejected.
- `underflow`, out, 1: sticky; a read was rejected.

## Operation
- Storage is DEPTH × DATA_WIDTH memory. Read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Occupancy is held in registered `fifo_cnt`. `full`, `empty`, `almost_full` and `almost_empty` are decoded combinationally from `fifo_cnt`.
- `wr_acc` = `writeEnable` && (!`full` || `readEnable`).
- `rd_acc` = `readEnable` && !`empty`.
- On `wr_acc`: store `data_in` at the write pointer, then increment the write pointer.
- On `rd_acc`: load `data_out` from the read pointer, then increment the read pointer.
- Otherwise `data_out` holds its value.
- Count update: +1 on `wr_acc` && !`rd_acc`; −1 on `rd_acc` && !`wr_acc`; unchanged otherwise. The count can never leave 0..DEPTH.
- Full with both requests: read and write both happen and the count stays at DEPTH. The write uses the slot the read frees in the same edge; the read returns the old word.
- Empty with both requests: only the write is accepted (no fall-through), count goes to 1, and `data_out` holds.
- Errors, when compiled in:
  - `overflow` sets on `writeEnable` && `full` && !`readEnable`.
  - `underflow` sets on `readEnable` && `empty`.
  - Both stay set until `err_clr` or reset. If set and `err_clr` occur on the same edge, set wins.
- Rejected operations never modify memory, pointers or count.

## Timing
- Reset (`rst` low, asynchronous) values:
  - pointers 0, `fifo_cnt` 0, `data_out` 0;
  - `empty` 1, `full` 0, `almost_empty` 1, `almost_full` 0;
  - `overflow` 0, `underflow` 0.
- Memory contents are not reset.
- Reset release is taken synchronously by the design's integration. The first edge with `rst` high may accept operations.
- Reset asserted mid-operation discards all contents immediately; the FIFO reads as empty.
- Read latency is 1 cycle: data is valid on `data_out` after the edge where `rd_acc` is true.
- Write-to-read latency: a word written at edge N is readable with `readEnable` at edge N+1 (`empty` falls after edge N).
- All flags and `fifo_cnt` change only in response to a clock edge or to reset.

## Configuration
- Macro `SYNC_FIFO_ERR_EN`.
- When defined: the `overflow`/`underflow` sticky logic and `err_clr` are implemented as described.
- When not defined: `overflow` and `underflow` are tied to 0, `err_clr` is ignored, and no error registers are instantiated. Port list is identical in both builds.

## Test plan
- Reset then idle: `empty`=1, `full`=0, `fifo_cnt`=0, `almost_empty`=1, `data_out`=0. Assert `rst` low mid-stream with count 5 → all outputs return to these values immediately, without a clock edge.
- Write 16 words 0x00..0x0F → `full`=1, `fifo_cnt`=16. `almost_full` rises when count reaches 14. A 17th write → count stays 16 and, with the macro, `overflow`=1.
- Read 16 words from full → `data_out` shows 0x00..0x0F in order, each one cycle after its read. `almost_empty` rises at count 2 and `empty` at 0. An extra read gives `underflow`=1 and `data_out` holds 0x0F.
- Wrap-around: write 10, read 10, write 12, read 12 with distinct data → read order matches write order exactly and pointers cross DEPTH-1→0 cleanly.
- Simultaneous at full: with count 16, apply write 0xAA plus read in one cycle → `data_out` = oldest word, count stays 16, no overflow. 0xAA is the 16th word read afterwards.
- Simultaneous at empty: apply write 0x55 plus read → count 1, `underflow`=1 (macro on), `data_out` unchanged. Next read returns 0x55. Pulse `err_clr` → both flags clear.
